decode_stage: RTL
=================

# decode_stage

Registered instruction-decode pipeline stage for the RV32I core. It sits between fetch and execute, takes one 32-bit instruction plus its PC per valid/ready beat, and fully decodes it. Decoding covers operand fields, a sign-extended immediate and the datapath control bits. Results are registered, and a one-entry skid buffer lets back-pressure from execute stall fetch without combinational ready paths or lost instructions.

## Interface
- XLEN, 32: immediate width; 32 or 64; immediates sign-extended to XLEN.
- PC_W, 32: PC width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  stage accepts an instruction (registered).
- i_inst  in  32  instruction word.
- i_pc  in  PC_W  instruction address.
- i_flush  in  1  discard all held instructions.
- o_valid  out  1  decoded instruction present.
- i_ready  in  1  execute accepts the decoded instruction.
- o_pc  out  PC_W  PC of decoded instruction.
- o_immediate  out  XLEN  sign-extended immediate.
- o_opcode  out  5  inst[6:2].
- o_funct3 / o_funct7  out  3 / 7  inst[14:12] / inst[31:25].
- o_rsa / o_rsb / o_rd  out  5 each  inst[19:15] / inst[24:20] / inst[11:7].
- o_hz_rsa / o_hz_rsb  out  1 each  instruction reads rs1 / rs2.
- o_alu_pc / o_alu_imm / o_alu_en  out  1 each  ALU A=PC, ALU B=imm, ALU used.
- o_ma_wr / o_ma_rd  out  1 each  store / load.
- o_wb_mux  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate.
- o_wb_en  out  1  register writeback.
- o_illegal  out  1  illegal instruction flag.

## Operation
- Immediate formats: I for LOAD/OP-IMM/JALR; S for STORE; B for BRANCH; U for LUI/AUIPC; J for JAL; zero otherwise.
- Control bits per opcode class (all unlisted bits are 0):
  - LOAD: hz_rsa, alu_imm, alu_en, ma_rd, wb_mux=01, wb_en.
  - OP-IMM: hz_rsa, alu_imm, alu_en, wb_en.
  - AUIPC: alu_pc, alu_imm, alu_en, wb_en.
  - STORE: hz_rsa, hz_rsb, alu_imm, alu_en, ma_wr.
  - OP: hz_rsa, hz_rsb, alu_en, wb_en.
  - LUI: alu_imm, wb_mux=11, wb_en.
  - BRANCH: hz_rsa, hz_rsb, alu_pc, alu_imm, alu_en.
  - JALR: hz_rsa, alu_imm, alu_en, wb_mux=10, wb_en.
  - JAL: alu_pc, alu_imm, alu_en, wb_mux=10, wb_en.
  - Any other class: all control bits 0.
- o_wb_en is forced 0 when rd==0.
- Storage: output register (OUT) plus skid register (SKID), each holding a valid bit.
- Accept = i_valid & o_ready; output handshake = o_valid & i_ready.
- When accepting:
  - OUT empty, or OUT draining this cycle with SKID empty: load OUT.
  - Otherwise: load SKID.
- On output handshake with SKID valid: SKID moves to OUT.
- Instructions always leave in arrival order.
- o_ready(next) = !SKID.valid(next).
- i_flush: OUT.valid and SKID.valid clear on the next edge. No accept occurs that cycle. o_ready is 1 afterwards. Flush beats a simultaneous handshake.

## Timing
- Latency: accepted on edge N, visible on o_valid after edge N.
- Throughput: 1/cycle while i_ready=1.
- o_ready depends only on registers.
- Reset (async assert, sync deassert by system): o_valid=0, o_ready=1, all data and control outputs 0, both valid bits 0.
- Reset during a stall discards both entries.
- Outputs are held stable while o_valid & !i_ready.

## Configuration
- DECODE_ILLEGAL_EN defined: o_illegal=1 when inst[1:0]!=2'b11, or the class is not one of the nine above nor MISC-MEM/SYSTEM, or OP has funct7 not in {0000000, 0100000}. When o_illegal=1, wb_en, ma_wr and ma_rd are forced 0 and the instruction still flows with o_valid.
- DECODE_ILLEGAL_EN undefined: o_illegal is tied 0. Unknown classes decode with all control bits 0.

## Test plan
- Reset with i_rst_n=0 mid-stream -> o_valid=0, o_ready=1, all outputs 0 immediately, without waiting for a clock edge.
- 0x555550b7 (LUI x1), i_ready=1 -> next cycle o_immediate=0x55555000, o_rd=1, o_wb_mux=11, o_wb_en=1, o_alu_imm=1.
- 0xaa000523 (SB) -> o_immediate=0xFFFFFAAA (XLEN=64: 0xFFFFFFFFFFFFFAAA), o_ma_wr=1, o_hz_rsa=1, o_hz_rsb=1, o_wb_en=0.
- 0x5545506f (JAL x0) -> o_immediate=0x00055554, o_alu_pc=1, o_wb_mux=10, o_wb_en=0.
- Back-pressure:
  - Setup: i_ready=0; push PCs 0x0, 0x4, 0x8 back-to-back.
  - Response: 0x0 lands in OUT and 0x4 in SKID; o_ready=0 from the following cycle; 0x8 is held.
  - Then: raise i_ready -> outputs 0x0, 0x4, 0x8 in order.
- Flush and illegal:
  - Flush with OUT and SKID full -> o_valid=0 and o_ready=1 next cycle.
  - 0x00000000 -> o_illegal=1 with DECODE_ILLEGAL_EN, 0 without; controls 0 in both builds.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: full decode of one instruction per beat into registered outputs, with a one-entry skid buffer.
// Latency: 1 cycle (accepted on edge N, visible after edge N); throughput 1/cycle while i_ready=1.
// Backpressure: o_ready comes straight from the skid valid flop, so there is no combinational ready path.
// Optional: define DECODE_ILLEGAL_EN to flag illegal encodings on o_illegal.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [XLEN-1:0] o_immediate,
  output logic [4:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rsa,
  output logic [4:0]      o_rsb,
  output logic [4:0]      o_rd,
  output logic            o_hz_rsa,
  output logic            o_hz_rsb,
  output logic            o_alu_pc,
  output logic            o_alu_imm,
  output logic            o_alu_en,
  output logic            o_ma_wr,
  output logic            o_ma_rd,
  output logic [1:0]      o_wb_mux,
  output logic            o_wb_en,
  output logic            o_illegal
);

  // inst[6:2] major opcode classes
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
`ifdef DECODE_ILLEGAL_EN
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
`endif

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rsa;
    logic [4:0]      rsb;
    logic [4:0]      rd;
    logic            hz_rsa;
    logic            hz_rsb;
    logic            alu_pc;
    logic            alu_imm;
    logic            alu_en;
    logic            ma_wr;
    logic            ma_rd;
    logic [1:0]      wb_mux;
    logic            wb_en;
    logic            illegal;
  } dec_t;

  dec_t        dec_d;
  dec_t        out_q, skid_q;
  logic        out_vld_q, skid_vld_q;
  logic        out_vld_d, skid_vld_d;
  logic        accept, out_hs, load_out, load_skid;
  logic [31:0] imm32;
  logic        is32;

  // Combinational decode of the incoming instruction; 16-bit encodings (inst[1:0]!=11) match no class.
  always_comb begin
    dec_d        = '0;
    imm32        = '0;
    is32         = (i_inst[1:0] == 2'b11);
    dec_d.pc     = i_pc;
    dec_d.opcode = i_inst[6:2];
    dec_d.funct3 = i_inst[14:12];
    dec_d.funct7 = i_inst[31:25];
    dec_d.rsa    = i_inst[19:15];
    dec_d.rsb    = i_inst[24:20];
    dec_d.rd     = i_inst[11:7];
    if (is32) begin
      case (i_inst[6:2])
        OPC_LOAD: begin
          imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
          {dec_d.hz_rsa, dec_d.alu_imm, dec_d.alu_en, dec_d.ma_rd, dec_d.wb_en} = 5'b11111;
          dec_d.wb_mux = 2'b01;
        end
        OPC_OPIMM: begin
          imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
          {dec_d.hz_rsa, dec_d.alu_imm, dec_d.alu_en, dec_d.wb_en} = 4'b1111;
        end
        OPC_AUIPC: begin
          imm32 = {i_inst[31:12], 12'b0};
          {dec_d.alu_pc, dec_d.alu_imm, dec_d.alu_en, dec_d.wb_en} = 4'b1111;
        end
        OPC_STORE: begin
          imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
          {dec_d.hz_rsa, dec_d.hz_rsb, dec_d.alu_imm, dec_d.alu_en, dec_d.ma_wr} = 5'b11111;
        end
        OPC_OP: begin
          {dec_d.hz_rsa, dec_d.hz_rsb, dec_d.alu_en, dec_d.wb_en} = 4'b1111;
        end
        OPC_LUI: begin
          imm32 = {i_inst[31:12], 12'b0};
          {dec_d.alu_imm, dec_d.wb_en} = 2'b11;
          dec_d.wb_mux = 2'b11;
        end
        OPC_BRANCH: begin
          imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
          {dec_d.hz_rsa, dec_d.hz_rsb, dec_d.alu_pc, dec_d.alu_imm, dec_d.alu_en} = 5'b11111;
        end
        OPC_JALR: begin
          imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
          {dec_d.hz_rsa, dec_d.alu_imm, dec_d.alu_en, dec_d.wb_en} = 4'b1111;
          dec_d.wb_mux = 2'b10;
        end
        OPC_JAL: begin
          imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
          {dec_d.alu_pc, dec_d.alu_imm, dec_d.alu_en, dec_d.wb_en} = 4'b1111;
          dec_d.wb_mux = 2'b10;
        end
        default: ;
      endcase
    end
    dec_d.imm = XLEN'($signed(imm32));
    // x0 is never written back
    if (dec_d.rd == 5'd0) dec_d.wb_en = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    case (i_inst[6:2])
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_LUI, OPC_BRANCH,
      OPC_JALR, OPC_JAL, OPC_MISC, OPC_SYSTEM: dec_d.illegal = !is32;
      OPC_OP: dec_d.illegal = !is32 || ((i_inst[31:25] != 7'b0000000) && (i_inst[31:25] != 7'b0100000));
      default: dec_d.illegal = 1'b1;
    endcase
    // illegal instructions still flow but must not touch architectural state
    if (dec_d.illegal) begin
      dec_d.wb_en = 1'b0;
      dec_d.ma_wr = 1'b0;
      dec_d.ma_rd = 1'b0;
    end
`else
    dec_d.illegal = 1'b0;
`endif
  end

  // Handshake and steering: while SKID is full o_ready is 0, so an accept always finds SKID empty.
  always_comb begin
    accept    = i_valid & ~skid_vld_q & ~i_flush;
    out_hs    = out_vld_q & i_ready;
    load_out  = accept & (~out_vld_q | out_hs);
    load_skid = accept & ~load_out;
    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      out_vld_d  = load_out | (out_hs & skid_vld_q) | (out_vld_q & ~out_hs);
      skid_vld_d = load_skid | (skid_vld_q & ~out_hs);
    end
  end

  // Valid flags for OUT and SKID
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Payload registers: OUT takes new decode or the older SKID entry; SKID only captures on overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) out_q <= dec_d;
      else if (out_hs && skid_vld_q && !i_flush) out_q <= skid_q;
      if (load_skid) skid_q <= dec_d;
    end
  end

  assign o_ready     = ~skid_vld_q;
  assign o_valid     = out_vld_q;
  assign o_pc        = out_q.pc;
  assign o_immediate = out_q.imm;
  assign o_opcode    = out_q.opcode;
  assign o_funct3    = out_q.funct3;
  assign o_funct7    = out_q.funct7;
  assign o_rsa       = out_q.rsa;
  assign o_rsb       = out_q.rsb;
  assign o_rd        = out_q.rd;
  assign o_hz_rsa    = out_q.hz_rsa;
  assign o_hz_rsb    = out_q.hz_rsb;
  assign o_alu_pc    = out_q.alu_pc;
  assign o_alu_imm   = out_q.alu_imm;
  assign o_alu_en    = out_q.alu_en;
  assign o_ma_wr     = out_q.ma_wr;
  assign o_ma_rd     = out_q.ma_rd;
  assign o_wb_mux    = out_q.wb_mux;
  assign o_wb_en     = out_q.wb_en;
  assign o_illegal   = out_q.illegal;

endmodule
